lvt_wr_ctrl: RTL and testbench

LVT_WR_CTRL -- requirements
Module: lvt_wr_ctrl

---
 rtl/lvt_wr_ctrl_if.sv | 15 +
 rtl/lvt_wr_ctrl.sv | 117 +++++++++++
 tb/tb_lvt_wr_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lvt_wr_ctrl_if.sv
// Request side of the LVT write controller: eight valid/ready requesters.
// Pure wiring bundle; no storage, no latency.
// Backpressure: requester holds valid/addr/data until it samples ready high.
interface lvt_wr_ctrl_if #(
  parameter int BLOCKSIZE = 10,
  parameter int DW        = 32
);
  logic [7:0]                   req_valid;
  logic [8*(BLOCKSIZE+1)-1:0]   req_addr;
  logic [8*DW-1:0]              req_data;
  logic [7:0]                   req_ready;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/lvt_wr_ctrl.sv
// Write-side controller for an 8R8W LVT RAM: arbitrates 8 requesters and runs clear sweeps.
// Latency: accepted request appears on its write port 1 cycle later (registered outputs).
// Backpressure: ready is low during sweeps, on clr_start, and for same-address losers (lower index wins).
module lvt_wr_ctrl #(
  parameter int            BLOCKSIZE = 10,
  parameter int            DW        = 32,
  parameter logic [DW-1:0] INIT_VAL  = '0
) (
  input  logic               clk,
  input  logic               rst,
  lvt_wr_ctrl_if.slave       req,
  input  logic               clr_start,
  output logic [BLOCKSIZE:0] w_addr_1, w_addr_2, w_addr_3, w_addr_4,
  output logic [BLOCKSIZE:0] w_addr_5, w_addr_6, w_addr_7, w_addr_8,
  output logic [DW-1:0]      w_din_1, w_din_2, w_din_3, w_din_4,
  output logic [DW-1:0]      w_din_5, w_din_6, w_din_7, w_din_8,
  output logic               w_enb_1, w_enb_2, w_enb_3, w_enb_4,
  output logic               w_enb_5, w_enb_6, w_enb_7, w_enb_8,
  output logic               busy,
  output logic               init_done
);
  localparam int AW = BLOCKSIZE + 1;
  localparam int PW = BLOCKSIZE - 2;

  typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic            ptr_last;
  logic [AW-1:0]   addr_s [8];
  logic [DW-1:0]   data_s [8];
  logic [7:0]      ready;
  logic            conflict;
  logic [AW-1:0]   wa [8];
  logic [DW-1:0]   wd [8];
  logic [7:0]      we;

  assign ptr_last = &ptr;

  for (genvar g = 0; g < 8; g++) begin : g_slice
    assign addr_s[g] = req.req_addr[g*AW +: AW];
    assign data_s[g] = req.req_data[g*DW +: DW];
  end

  // State register: reset always lands in SWEEP so the RAM is cleared before use.
  always_ff @(posedge clk) begin
    if (!rst) state <= SWEEP;
    else      state <= state_nxt;
  end

  // Next state: a sweep ends on the all-ones pointer; clr_start only counts in RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      SWEEP:   if (ptr_last)  state_nxt = RUN;
      RUN:     if (clr_start) state_nxt = SWEEP;
      default: state_nxt = SWEEP;
    endcase
  end

  // Outputs from state: busy, and per-requester ready with lowest-index-wins on address clashes.
  always_comb begin
    busy     = !rst || (state == SWEEP);
    ready    = '0;
    conflict = 1'b0;
    if (rst && state == RUN && !clr_start) begin
      for (int k = 0; k < 8; k++) begin
        conflict = 1'b0;
        for (int j = 0; j < k; j++) begin
          if (req.req_valid[j] && addr_s[j] == addr_s[k]) conflict = 1'b1;
        end
        ready[k] = req.req_valid[k] && !conflict;
      end
    end
  end

  assign req.req_ready = ready;

  // Sweep pointer, init flag and registered write ports; addr/data hold when a port is idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr       <= '0;
      init_done <= 1'b0;
      we        <= '0;
      for (int k = 0; k < 8; k++) begin
        wa[k] <= '0;
        wd[k] <= '0;
      end
    end else if (state == SWEEP) begin
      ptr <= ptr + PW'(1);
      if (ptr_last) init_done <= 1'b1;
      we  <= 8'hFF;
      for (int k = 0; k < 8; k++) begin
        wa[k] <= {ptr, 3'(k)};
        wd[k] <= INIT_VAL;
      end
    end else begin
      ptr <= '0;
      we  <= ready;
      for (int k = 0; k < 8; k++) begin
        if (ready[k]) begin
          wa[k] <= addr_s[k];
          wd[k] <= data_s[k];
        end
      end
    end
  end

  assign w_addr_1 = wa[0];  assign w_din_1 = wd[0];  assign w_enb_1 = we[0];
  assign w_addr_2 = wa[1];  assign w_din_2 = wd[1];  assign w_enb_2 = we[1];
  assign w_addr_3 = wa[2];  assign w_din_3 = wd[2];  assign w_enb_3 = we[2];
  assign w_addr_4 = wa[3];  assign w_din_4 = wd[3];  assign w_enb_4 = we[3];
  assign w_addr_5 = wa[4];  assign w_din_5 = wd[4];  assign w_enb_5 = we[4];
  assign w_addr_6 = wa[5];  assign w_din_6 = wd[5];  assign w_enb_6 = we[5];
  assign w_addr_7 = wa[6];  assign w_din_7 = wd[6];  assign w_enb_7 = we[6];
  assign w_addr_8 = wa[7];  assign w_din_8 = wd[7];  assign w_enb_8 = we[7];
endmodule

// File: tb/tb_lvt_wr_ctrl.sv
// Bench for lvt_wr_ctrl: emulates the RAM behind the write ports and compares
// against an expected-memory model, plus vector table and corner sequences.
module tb_lvt_wr_ctrl;
  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int WORDS = 2048;

  logic clk, rst, clr_start;
  lvt_wr_ctrl_if #(.BLOCKSIZE(10), .DW(DW)) bus ();

  logic [AW-1:0] w_addr_1, w_addr_2, w_addr_3, w_addr_4, w_addr_5, w_addr_6, w_addr_7, w_addr_8;
  logic [DW-1:0] w_din_1, w_din_2, w_din_3, w_din_4, w_din_5, w_din_6, w_din_7, w_din_8;
  logic          w_enb_1, w_enb_2, w_enb_3, w_enb_4, w_enb_5, w_enb_6, w_enb_7, w_enb_8;
  logic          busy, init_done;

  lvt_wr_ctrl #(.BLOCKSIZE(10), .DW(DW), .INIT_VAL('0)) dut (
    .clk(clk), .rst(rst), .req(bus.slave), .clr_start(clr_start),
    .w_addr_1(w_addr_1), .w_addr_2(w_addr_2), .w_addr_3(w_addr_3), .w_addr_4(w_addr_4),
    .w_addr_5(w_addr_5), .w_addr_6(w_addr_6), .w_addr_7(w_addr_7), .w_addr_8(w_addr_8),
    .w_din_1(w_din_1), .w_din_2(w_din_2), .w_din_3(w_din_3), .w_din_4(w_din_4),
    .w_din_5(w_din_5), .w_din_6(w_din_6), .w_din_7(w_din_7), .w_din_8(w_din_8),
    .w_enb_1(w_enb_1), .w_enb_2(w_enb_2), .w_enb_3(w_enb_3), .w_enb_4(w_enb_4),
    .w_enb_5(w_enb_5), .w_enb_6(w_enb_6), .w_enb_7(w_enb_7), .w_enb_8(w_enb_8),
    .busy(busy), .init_done(init_done)
  );

  logic [AW-1:0] wa_a [8];
  logic [DW-1:0] wd_a [8];
  logic [7:0]    we_a;
  assign wa_a[0] = w_addr_1; assign wa_a[1] = w_addr_2; assign wa_a[2] = w_addr_3; assign wa_a[3] = w_addr_4;
  assign wa_a[4] = w_addr_5; assign wa_a[5] = w_addr_6; assign wa_a[6] = w_addr_7; assign wa_a[7] = w_addr_8;
  assign wd_a[0] = w_din_1;  assign wd_a[1] = w_din_2;  assign wd_a[2] = w_din_3;  assign wd_a[3] = w_din_4;
  assign wd_a[4] = w_din_5;  assign wd_a[5] = w_din_6;  assign wd_a[6] = w_din_7;  assign wd_a[7] = w_din_8;
  assign we_a = {w_enb_8, w_enb_7, w_enb_6, w_enb_5, w_enb_4, w_enb_3, w_enb_2, w_enb_1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    valid;
    logic [AW-1:0] addr [8];
    logic [7:0]    exp_ready;
  } vec_t;

  logic [DW-1:0] ram       [WORDS];
  logic [DW-1:0] model_mem [WORDS];
  int            hits      [WORDS];
  int            map_err, collisions;
  int            checks, errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Emulated RAM plus per-cycle bookkeeping of what the write ports did.
  task automatic observe();
    for (int k = 0; k < 8; k++) begin
      if (we_a[k] === 1'b1) begin
        ram[wa_a[k]] = wd_a[k];
        hits[wa_a[k]]++;
        if (wa_a[k][2:0] !== 3'(k)) map_err++;
        for (int j = k + 1; j < 8; j++)
          if (we_a[j] === 1'b1 && wa_a[j] === wa_a[k]) collisions++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic set_req(input int k, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[k]            = v;
    bus.req_addr[k*AW +: AW]    = a;
    bus.req_data[k*DW +: DW]    = d;
  endtask

  function automatic int ram_diff();
    int n = 0;
    for (int i = 0; i < WORDS; i++) if (ram[i] !== model_mem[i]) n++;
    return n;
  endfunction

  // Follows a sweep from its first busy cycle to the cycle busy drops.
  task automatic run_sweep(output int cyc, output int early, output int rviol, output int bad_hits);
    for (int i = 0; i < WORDS; i++) hits[i] = 0;
    map_err = 0; cyc = 0; early = 0; rviol = 0; bad_hits = 0;
    while (busy === 1'b1 && cyc < 400) begin
      if (bus.req_ready !== 8'h00) rviol++;
      tick();
      cyc++;
      if (busy === 1'b1 && init_done === 1'b1) early++;
    end
    for (int i = 0; i < WORDS; i++) begin
      if (hits[i] != 1) bad_hits++;
      model_mem[i] = '0;
    end
  endtask

  vec_t          tv [8];
  logic [7:0]    pv, exp_rdy, mism;
  logic [AW-1:0] pa [8];
  logic [DW-1:0] pd [8];
  logic [AW-1:0] seen [$];
  int            cyc, early, rviol, bad_hits, dmis;

  initial begin
    checks = 0; errors = 0; collisions = 0; map_err = 0;
    for (int i = 0; i < WORDS; i++) begin ram[i] = 32'hDEADBEEF; model_mem[i] = '0; hits[i] = 0; end
    rst = 1'b0; clr_start = 1'b0;
    bus.req_valid = 8'hFF; bus.req_addr = '0; bus.req_data = '0;

    // Reset: busy high and ready low, even with every requester valid.
    #1;
    check("reset_busy_pre_edge", busy, 1);
    check("reset_ready_pre_edge", bus.req_ready, 0);
    tick(); tick(); tick();
    check("reset_busy", busy, 1);
    check("reset_ready", bus.req_ready, 0);
    check("reset_enb", we_a, 0);
    check("reset_init_done", init_done, 0);
    bus.req_valid = 8'h00;
    rst = 1'b1;

    // Initial sweep: 256 cycles, every word once, on port (addr mod 8)+1.
    run_sweep(cyc, early, rviol, bad_hits);
    check("init_sweep_cycles", cyc, 256);
    check("init_sweep_hits", bad_hits, 0);
    check("init_sweep_port_map", map_err, 0);
    check("init_done_early", early, 0);
    check("init_done_set", init_done, 1);
    check("init_ram_cleared", ram_diff(), 0);
    tick();
    check("idle_enb", we_a, 0);

    // Vector table of single-cycle request patterns.
    for (int k = 0; k < 8; k++) begin
      tv[0].addr[k] = 11'h010 + 11'(k);
      tv[1].addr[k] = 11'h123;
      tv[2].addr[k] = 11'h200;
      tv[3].addr[k] = 11'h000;
      tv[4].addr[k] = 11'h050 + 11'(k % 2);
      tv[5].addr[k] = 11'h7FF;
      tv[6].addr[k] = (k == 2) ? 11'h034 : 11'h033;
      tv[7].addr[k] = 11'(k / 2);
    end
    tv[0].valid = 8'hFF; tv[0].exp_ready = 8'hFF;
    tv[1].valid = 8'h12; tv[1].exp_ready = 8'h02;
    tv[2].valid = 8'hFF; tv[2].exp_ready = 8'h01;
    tv[3].valid = 8'h00; tv[3].exp_ready = 8'h00;
    tv[4].valid = 8'hF0; tv[4].exp_ready = 8'h30;
    tv[5].valid = 8'h81; tv[5].exp_ready = 8'h01;
    tv[6].valid = 8'h0E; tv[6].exp_ready = 8'h06;
    tv[7].valid = 8'hAA; tv[7].exp_ready = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++)
        set_req(k, tv[i].valid[k], tv[i].addr[k], 32'hA0 + 32'(k) + 32'(i << 8));
      #1;
      check($sformatf("vec%0d_ready", i), bus.req_ready, tv[i].exp_ready);
      tick();
      bus.req_valid = 8'h00;
      check($sformatf("vec%0d_enb", i), we_a, tv[i].exp_ready);
      dmis = 0;
      for (int k = 0; k < 8; k++) begin
        if (tv[i].exp_ready[k]) begin
          model_mem[tv[i].addr[k]] = 32'hA0 + 32'(k) + 32'(i << 8);
          if (wa_a[k] !== tv[i].addr[k] || wd_a[k] !== 32'hA0 + 32'(k) + 32'(i << 8)) dmis++;
        end
      end
      check($sformatf("vec%0d_port_data", i), dmis, 0);
      tick();
    end
    check("vec0_ram_0x17", ram[11'h017], 32'hA7);

    // Same-address pair: requester 2 wins first, requester 5 follows, 5's data remains.
    set_req(1, 1'b1, 11'h123, 32'h22);
    set_req(4, 1'b1, 11'h123, 32'h55);
    #1;
    check("pair_ready_first", bus.req_ready, 8'h02);
    tick();
    bus.req_valid[1] = 1'b0;
    #1;
    check("pair_enb_first", we_a, 8'h02);
    check("pair_din_first", wd_a[1], 32'h22);
    check("pair_ready_second", bus.req_ready, 8'h10);
    tick();
    bus.req_valid[4] = 1'b0;
    check("pair_enb_second", we_a, 8'h10);
    tick();
    check("pair_ram_final", ram[11'h123], 32'h55);
    model_mem[11'h123] = 32'h55;

    // Randomised traffic over a small address window to force clashes and stalls.
    pv = '0;
    dmis = 0;
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < 8; k++) begin
        if (!pv[k] && $urandom_range(0, 2) == 0) begin
          pv[k] = 1'b1;
          pa[k] = 11'h040 + 11'($urandom_range(0, 7));
          pd[k] = $urandom;
        end
        set_req(k, pv[k], pa[k], pd[k]);
      end
      #1;
      // First valid claimant of each address is granted; later ones wait.
      seen.delete();
      exp_rdy = '0;
      for (int k = 0; k < 8; k++) begin
        if (pv[k]) begin
          if (!(pa[k] inside {seen})) exp_rdy[k] = 1'b1;
          seen.push_back(pa[k]);
        end
      end
      check("rand_ready", bus.req_ready, exp_rdy);
      tick();
      check("rand_enb", we_a, exp_rdy);
      for (int k = 0; k < 8; k++) begin
        if (exp_rdy[k]) begin
          if (wa_a[k] !== pa[k] || wd_a[k] !== pd[k]) dmis++;
          model_mem[pa[k]] = pd[k];
          pv[k] = 1'b0;
        end
      end
    end
    check("rand_port_data", dmis, 0);
    bus.req_valid = 8'h00;
    tick();
    check("rand_ram_contents", ram_diff(), 0);

    // Clear pulse with requester 1 pending: stalled through the sweep, accepted on first RUN cycle.
    set_req(0, 1'b1, 11'h300, 32'h1234);
    clr_start = 1'b1;
    #1;
    check("clr_ready_zero", bus.req_ready, 0);
    tick();
    clr_start = 1'b0;
    run_sweep(cyc, early, rviol, bad_hits);
    check("clr_sweep_cycles", cyc, 256);
    check("clr_sweep_ready_held", rviol, 0);
    check("clr_sweep_hits", bad_hits, 0);
    check("clr_first_run_ready", bus.req_ready, 8'h01);
    tick();
    bus.req_valid = 8'h00;
    check("clr_req_enb", we_a, 8'h01);
    model_mem[11'h300] = 32'h1234;
    tick();
    check("clr_ram_contents", ram_diff(), 0);
    check("hold_addr", w_addr_1, 11'h300);
    check("hold_din", w_din_1, 32'h1234);

    // Reset in the middle of a sweep restarts it from scratch.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    rst = 1'b0;
    bus.req_valid = 8'h01;
    tick();
    check("midrst_enb", we_a, 0);
    check("midrst_addr8", w_addr_8, 0);
    check("midrst_init_done", init_done, 0);
    check("midrst_ready", bus.req_ready, 0);
    tick();
    check("midrst_enb2", we_a, 0);
    check("midrst_busy", busy, 1);
    bus.req_valid = 8'h00;
    rst = 1'b1;
    run_sweep(cyc, early, rviol, bad_hits);
    check("midrst_sweep_cycles", cyc, 256);
    check("midrst_init_done_early", early, 0);
    check("midrst_sweep_hits", bad_hits, 0);
    check("midrst_init_done_set", init_done, 1);

    // clr_start held through a sweep: one sweep, then an immediate new one.
    clr_start = 1'b1;
    tick();
    check("hold_clr_busy", busy, 1);
    run_sweep(cyc, early, rviol, bad_hits);
    check("hold_clr_cycles", cyc, 256);
    check("hold_clr_hits", bad_hits, 0);
    check("hold_clr_run_busy", busy, 0);
    tick();
    check("hold_clr_restart", busy, 1);
    clr_start = 1'b0;
    run_sweep(cyc, early, rviol, bad_hits);
    check("hold_clr_second_cycles", cyc, 256);
    check("final_ram_contents", ram_diff(), 0);
    check("no_port_collisions", collisions, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
